// File: rtl/bcdtobin.sv
// ---------------------------------------------------------------------------
// bcdtobin
// Sequential signed-BCD to two's-complement binary converter. It turns
// keypad-entered digit strings into signed ALU operands. It is the inverse of
// the display's binary-to-BCD path.
//
// The input word is a sign nibble followed by NDIG BCD digits, most
// significant digit first. The sign nibble is 4'hF for positive and 4'hE for
// negative. The magnitude is recovered with reverse double dabble, one digit
// bit per clock: shift the scratch register right, then subtract 3 from every
// digit nibble that reads 8 or more.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only while idle
//   bcdnum   : {sign[3:0], NDIG BCD digits}
//   busy     : conversion in progress
//   done     : one-cycle pulse, the cycle after bin/ovf/invalid update
//   bin      : signed BINW-bit result
//   ovf      : magnitude does not fit a BINW-bit signed value
//   invalid  : bad sign nibble, or a digit greater than 9
// ---------------------------------------------------------------------------
module bcdtobin #(
    parameter int NDIG = 7,
    parameter int BINW = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG+3:0] bcdnum,
    output logic              busy,
    output logic              done,
    output logic [BINW-1:0]   bin,
    output logic              ovf,
    output logic              invalid
);

    localparam int MAGW = 4 * NDIG;
    localparam int SCRW = 2 * MAGW;
    localparam int CNTW = $clog2(MAGW + 1);

    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(MAGW - 1);
    localparam logic [MAGW-1:0] POS_MAX   = MAGW'((64'd1 << (BINW - 1)) - 64'd1);
    localparam logic [MAGW-1:0] NEG_MAX   = MAGW'(64'd1 << (BINW - 1));

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [SCRW-1:0] scr_q, scr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            inv_q, inv_d;
    logic            finish_q;
    logic            done_q;
    logic [BINW-1:0] bin_q, bin_d;
    logic            ovf_q, ovf_d;
    logic            invalid_q, invalid_d;

    logic [3:0]      signNib;
    logic [MAGW-1:0] digits;
    logic [MAGW-1:0] mag;
    logic            signOk;

    // Reports whether any digit nibble lies outside 0..9.
    function automatic logic digitsBad(input logic [MAGW-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Runs one reverse double dabble step. The register shifts right by one.
    // Then every digit nibble in the upper half that reads 8 or more drops
    // by 3. This undoes the +3 correction of forward double dabble.
    function automatic logic [SCRW-1:0] dabbleStep(input logic [SCRW-1:0] s);
        logic [SCRW-1:0] r;
        logic [3:0]      nib;
        r = s >> 1;
        for (int i = 0; i < NDIG; i++) begin
            nib = r[MAGW + 4*i +: 4];
            if (nib >= 4'd8) begin
                r[MAGW + 4*i +: 4] = nib - 4'd3;
            end
        end
        return r;
    endfunction

    assign signNib = bcdnum[MAGW+3:MAGW];
    assign digits  = bcdnum[MAGW-1:0];
    assign signOk  = (signNib == 4'hE) || (signNib == 4'hF);
    assign mag     = scr_q[MAGW-1:0];

    // Next-state logic.
    // The low BINW bits of a two's-complement negation depend only on the
    // low BINW bits of the operand. So negating the truncated magnitude gives
    // the same result as negating the full-width magnitude and truncating.
    // The range check still uses the full-width magnitude.
    always_comb begin
        state_d   = state_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        inv_d     = inv_q;
        bin_d     = bin_q;
        ovf_d     = ovf_q;
        invalid_d = invalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_d = (signNib == 4'hE);
                    if (!signOk || digitsBad(digits)) begin
                        inv_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        inv_d   = 1'b0;
                        scr_d   = {digits, MAGW'(0)};
                        cnt_d   = '0;
                        state_d = ST_CONV;
                    end
                end
            end

            ST_CONV: begin
                scr_d = dabbleStep(scr_q);
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                if (inv_q) begin
                    bin_d     = '0;
                    ovf_d     = 1'b0;
                    invalid_d = 1'b1;
                end else if ((!neg_q && (mag > POS_MAX)) || (neg_q && (mag > NEG_MAX))) begin
                    bin_d     = '0;
                    ovf_d     = 1'b1;
                    invalid_d = 1'b0;
                end else begin
                    bin_d     = neg_q ? (BINW'(0) - mag[BINW-1:0]) : mag[BINW-1:0];
                    ovf_d     = 1'b0;
                    invalid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    // done trails the FINISH edge by one cycle. finish_q carries that edge
    // forward. A reset that lands in FINISH therefore never yields a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scr_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            inv_q     <= 1'b0;
            finish_q  <= 1'b0;
            done_q    <= 1'b0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            inv_q     <= inv_d;
            finish_q  <= (state_q == ST_FINISH);
            done_q    <= finish_q;
            bin_q     <= bin_d;
            ovf_q     <= ovf_d;
            invalid_q <= invalid_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign bin     = bin_q;
    assign ovf     = ovf_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcdtobin.sv
// ---------------------------------------------------------------------------
// tb_bcdtobin
// Scoreboard bench for bcdtobin.
//
// The stimulus side pushes the hand-computed result for each accepted
// request. That result includes the cycle at which done must fire. An
// independent monitor pops an entry on every done pulse and compares it.
// ---------------------------------------------------------------------------
module tb_bcdtobin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bcdnum;
    logic        busy;
    logic        done;
    logic [20:0] bin;
    logic        ovf;
    logic        invalid;

    typedef struct {
        string       name;
        logic [20:0] bin;
        logic        ovf;
        logic        inv;
        int          doneCyc;
    } exp_t;

    exp_t sbQ[$];
    exp_t monE;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bcdtobin #(.NDIG(7), .BINW(21)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcdnum  (bcdnum),
        .busy    (busy),
        .done    (done),
        .bin     (bin),
        .ovf     (ovf),
        .invalid (invalid)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running count of rising edges, used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Compares one value and logs any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Queues the expected result of a request accepted at the next rising edge.
    task automatic pushExp(input string name, input logic [20:0] b, input logic o,
                           input logic i, input int lat);
        exp_t e;
        e.name    = name;
        e.bin     = b;
        e.ovf     = o;
        e.inv     = i;
        e.doneCyc = cyc + 1 + lat;
        sbQ.push_back(e);
    endtask

    // Monitor: on each done pulse, retires the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
            end else begin
                monE = sbQ.pop_front();
                checkOutput({monE.name, ".bin"},     32'(bin),     32'(monE.bin));
                checkOutput({monE.name, ".ovf"},     32'(ovf),     32'(monE.ovf));
                checkOutput({monE.name, ".invalid"}, 32'(invalid), 32'(monE.inv));
                checkOutput({monE.name, ".done_cycle"}, 32'(cyc),  32'(monE.doneCyc));
            end
        end
    end

    // Waits for the scoreboard to empty, with a bounded number of cycles.
    // Counts busy samples along the way. The count starts at the current
    // falling edge, which is the first one after the accepting edge.
    task automatic waitDrain(input string name, input int expBusy);
        int busyCnt;
        busyCnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) busyCnt++;
            if (sbQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput({name, ".drain"}, 32'(sbQ.size()), 32'd0);
        sbQ.delete();
        if (expBusy >= 0) checkOutput({name, ".busy_cycles"}, 32'(busyCnt), 32'(expBusy));
    endtask

    // Issues one single-cycle request, then scrambles bcdnum after acceptance.
    task automatic applyStimulus(input string name, input logic [31:0] num,
                                 input logic [20:0] b, input logic o, input logic i);
        @(negedge clk);
        bcdnum = num;
        start  = 1'b1;
        pushExp(name, b, o, i, i ? 2 : 30);
        @(negedge clk);
        start  = 1'b0;
        bcdnum = 32'hDEAD_BEEF;
        waitDrain(name, i ? 1 : 29);
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcdnum = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy",    32'(busy),    32'd0);
        checkOutput("reset.done",    32'(done),    32'd0);
        checkOutput("reset.bin",     32'(bin),     32'd0);
        checkOutput("reset.ovf",     32'(ovf),     32'd0);
        checkOutput("reset.invalid", 32'(invalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversions.
        applyStimulus("pos123",  32'hF000_0123, 21'd123,     1'b0, 1'b0);
        applyStimulus("neg1234", 32'hE000_1234, 21'h1FFB2E,  1'b0, 1'b0);
        applyStimulus("negzero", 32'hE000_0000, 21'd0,       1'b0, 1'b0);
        applyStimulus("poszero", 32'hF000_0000, 21'd0,       1'b0, 1'b0);

        // Range limits.
        applyStimulus("posmax",  32'hF104_8575, 21'h0FFFFF,  1'b0, 1'b0);
        applyStimulus("posovf",  32'hF104_8576, 21'd0,       1'b1, 1'b0);
        applyStimulus("negmax",  32'hE104_8576, 21'h100000,  1'b0, 1'b0);
        applyStimulus("bigovf",  32'hF999_9999, 21'd0,       1'b1, 1'b0);

        // Invalid encodings, then recovery.
        applyStimulus("baddigit", 32'hF000_00A1, 21'd0,      1'b0, 1'b1);
        applyStimulus("badsign",  32'hC000_0001, 21'd0,      1'b0, 1'b1);
        applyStimulus("pos5",     32'hF000_0005, 21'd5,      1'b0, 1'b0);

        // A start pulse during a conversion is ignored.
        @(negedge clk);
        bcdnum = 32'hF000_0777;
        start  = 1'b1;
        pushExp("busy_start", 21'd777, 1'b0, 1'b0, 30);
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        bcdnum = 32'hF000_0001;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitDrain("busy_start", -1);

        // Reset mid-conversion aborts immediately, with no done pulse.
        @(negedge clk);
        bcdnum = 32'hF000_0777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy",    32'(busy),    32'd0);
        checkOutput("abort.done",    32'(done),    32'd0);
        checkOutput("abort.bin",     32'(bin),     32'd0);
        checkOutput("abort.ovf",     32'(ovf),     32'd0);
        checkOutput("abort.invalid", 32'(invalid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("abort.idle_busy", 32'(busy), 32'd0);
        applyStimulus("pos42", 32'hF000_0042, 21'd42, 1'b0, 1'b0);

        // Holding start high gives back-to-back conversions 30 cycles apart.
        @(negedge clk);
        bcdnum = 32'hF000_0010;
        start  = 1'b1;
        pushExp("b2b_10", 21'd10, 1'b0, 1'b0, 30);
        pushExp("b2b_20", 21'd20, 1'b0, 1'b0, 60);
        @(negedge clk);
        bcdnum = 32'hF000_0020;
        repeat (30) @(negedge clk);
        start  = 1'b0;
        bcdnum = 32'hDEAD_BEEF;
        waitDrain("b2b", -1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
